// File: rtl/register_pkg.sv
// -----------------------------------------------------------------------------
// register_pkg
// Shared datapath definitions for the generic storage register.
//   XLEN        : default datapath width (SIZE default of register)
//   ZERO_VALUE  : all-zero word, sliced to SIZE for the RESET_VALUE default
//   xor_reduce64: parity helper used by parity_gen and for the reset parity
// Optional feature macro used by consumers of this package: REGISTER_PARITY_EN
// -----------------------------------------------------------------------------
package register_pkg;

  localparam int XLEN = 32;

  // Widest legal SIZE is 64, so the zero constant is 64 bits and gets sliced.
  localparam logic [63:0] ZERO_VALUE = 64'd0;

  // Even-parity bit of a word zero-extended to 64 bits (extension adds no 1s).
  function automatic logic xor_reduce64(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/parity_gen.sv
// -----------------------------------------------------------------------------
// parity_gen
// SIZE-wide XOR reduction producing the even-parity bit of a data word.
// Only instantiated by register when REGISTER_PARITY_EN is defined.
// Ports:
//   data   : input  [SIZE-1:0] word to reduce
//   parity : output            XOR of all bits of data
// -----------------------------------------------------------------------------
module parity_gen
  import register_pkg::*;
#(
  parameter int SIZE = XLEN
) (
  input  logic [SIZE-1:0] data,
  output logic            parity
);

  // Pure combinational reduction through the shared helper.
  assign parity = xor_reduce64(64'(data));

endmodule

// File: rtl/register.sv
// -----------------------------------------------------------------------------
// register
// Generic parallel-load storage register used for the PC, pipeline/holding
// registers and instruction/data latches.
// Ports:
//   CLK        : input             rising-edge clock
//   RESET      : input             synchronous active-high reset (beats LOAD)
//   LOAD       : input             capture IN on the next rising edge
//   IN         : input  [SIZE-1:0] data to store
//   OUT        : output [SIZE-1:0] stored value, straight from flops
//   LOADED     : output            set by any load since the last reset
//   PARITY_ERR : output            (REGISTER_PARITY_EN only) parity of OUT
//                                  disagrees with the stored parity bit
// Optional feature macro: REGISTER_PARITY_EN
// -----------------------------------------------------------------------------
module register
  import register_pkg::*;
#(
  parameter int              SIZE        = XLEN,
  parameter logic [SIZE-1:0] RESET_VALUE = ZERO_VALUE[SIZE-1:0]
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            LOAD,
  input  logic [SIZE-1:0] IN,
  output logic [SIZE-1:0] OUT,
`ifdef REGISTER_PARITY_EN
  output logic            PARITY_ERR,
`endif
  output logic            LOADED
);

  // Data and loaded-flag storage: reset has priority, then load, else hold.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      OUT    <= RESET_VALUE;
      LOADED <= 1'b0;
    end else if (LOAD) begin
      OUT    <= IN;
      LOADED <= 1'b1;
    end else begin
      OUT    <= OUT;
      LOADED <= LOADED;
    end
  end

`ifdef REGISTER_PARITY_EN
  // Parity of the reset value is fixed at elaboration time.
  localparam logic RESET_PARITY = xor_reduce64(64'(RESET_VALUE));

  logic in_parity_s;
  logic out_parity_s;
  logic parity_r;

  parity_gen #(.SIZE(SIZE)) u_parity_in (
    .data   (IN),
    .parity (in_parity_s)
  );

  parity_gen #(.SIZE(SIZE)) u_parity_out (
    .data   (OUT),
    .parity (out_parity_s)
  );

  // Stored even-parity bit follows the same reset/load/hold priority as OUT.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      parity_r <= RESET_PARITY;
    end else if (LOAD) begin
      parity_r <= in_parity_s;
    end else begin
      parity_r <= parity_r;
    end
  end

  // Any single-bit corruption of OUT makes the combined parity odd.
  assign PARITY_ERR = out_parity_s ^ parity_r;
`endif

endmodule

// File: tb/tb_register.sv
// -----------------------------------------------------------------------------
// tb_register
// Scoreboard bench for register: two instances share stimulus, one with the
// default RESET_VALUE and one with 32'hDEADBEEF. Each driven edge pushes the
// hand-computed expected outputs; a monitor pops and compares after each edge.
// Optional feature macro: REGISTER_PARITY_EN
// -----------------------------------------------------------------------------
module tb_register;

  logic        clk;
  logic        reset;
  logic        load;
  logic [31:0] din;
  logic [31:0] out0;
  logic [31:0] out1;
  logic        loaded0;
  logic        loaded1;
`ifdef REGISTER_PARITY_EN
  logic        perr0;
  logic        perr1;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] out0;
    logic [31:0] out1;
    logic        loaded;
  } exp_t;

  exp_t exp_q[$];

  register dut0 (
    .CLK        (clk),
    .RESET      (reset),
    .LOAD       (load),
    .IN         (din),
    .OUT        (out0),
`ifdef REGISTER_PARITY_EN
    .PARITY_ERR (perr0),
`endif
    .LOADED     (loaded0)
  );

  register #(.SIZE(32), .RESET_VALUE(32'hDEADBEEF)) dut1 (
    .CLK        (clk),
    .RESET      (reset),
    .LOAD       (load),
    .IN         (din),
    .OUT        (out1),
`ifdef REGISTER_PARITY_EN
    .PARITY_ERR (perr1),
`endif
    .LOADED     (loaded1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Drive one edge's worth of inputs and queue the expected post-edge state.
  task automatic step(input logic r, input logic l, input logic [31:0] d,
                      input logic [31:0] e0, input logic [31:0] e1, input logic el);
    exp_t e;
    @(negedge clk);
    reset = r;
    load  = l;
    din   = d;
    @(posedge clk);
    e.out0   = e0;
    e.out1   = e1;
    e.loaded = el;
    exp_q.push_back(e);
  endtask

  // Monitor: compare both instances just after every edge that has an expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_default", out0, e.out0);
        check("out_override", out1, e.out1);
        check("loaded_default", {31'd0, loaded0}, {31'd0, e.loaded});
        check("loaded_override", {31'd0, loaded1}, {31'd0, e.loaded});
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    load  = 1'b0;
    din   = 32'd0;

    // Reset beats a simultaneous load.
    step(1'b1, 1'b1, 32'd45,  32'd0,  32'hDEADBEEF, 1'b0);
    // Basic load.
    step(1'b0, 1'b1, 32'd45,  32'd45, 32'd45, 1'b1);
    // Hold while IN changes.
    step(1'b0, 1'b0, 32'd450, 32'd45, 32'd45, 1'b1);
    step(1'b0, 1'b0, 32'd450, 32'd45, 32'd45, 1'b1);
    step(1'b0, 1'b0, 32'd7,   32'd45, 32'd45, 1'b1);
    // Back-to-back loads.
    step(1'b0, 1'b1, 32'd1,   32'd1,  32'd1,  1'b1);
    step(1'b0, 1'b1, 32'd2,   32'd2,  32'd2,  1'b1);
    step(1'b0, 1'b1, 32'd3,   32'd3,  32'd3,  1'b1);
    // Full-width patterns.
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    step(1'b0, 1'b1, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 1'b1);
    // Reset after data.
    step(1'b0, 1'b1, 32'd45,  32'd45, 32'd45, 1'b1);
    step(1'b1, 1'b0, 32'd45,  32'd0,  32'hDEADBEEF, 1'b0);
    // Held in reset state with LOAD low; LOADED stays clear.
    step(1'b0, 1'b0, 32'd9,   32'd0,  32'hDEADBEEF, 1'b0);
    // Reset mid-operation during a load streak: data on that edge is lost.
    step(1'b0, 1'b1, 32'd77,  32'd77, 32'd77, 1'b1);
    step(1'b1, 1'b1, 32'd99,  32'd0,  32'hDEADBEEF, 1'b0);
    step(1'b0, 1'b1, 32'd100, 32'd100, 32'd100, 1'b1);

`ifdef REGISTER_PARITY_EN
    step(1'b1, 1'b0, 32'd0,   32'd0,  32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check("perr_after_reset_default", {31'd0, perr0}, 32'd0);
    check("perr_after_reset_override", {31'd0, perr1}, 32'd0);
    step(1'b0, 1'b1, 32'h7,   32'h7,  32'h7,  1'b1);
    @(negedge clk);
    load = 1'b0;
    check("perr_after_load", {31'd0, perr0}, 32'd0);
    force dut0.OUT = 32'h6;
    #1;
    check("perr_after_flip", {31'd0, perr0}, 32'd1);
    release dut0.OUT;
    step(1'b0, 1'b1, 32'h5,   32'h5,  32'h5,  1'b1);
    @(negedge clk);
    check("perr_after_reload", {31'd0, perr0}, 32'd0);
`endif

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register.md
Name: register

Overview:
- Generic parallel-load storage register, SIZE bits wide.
- Used throughout the RISC-V datapath for the PC, pipeline/holding registers, and instruction/data latches.
- Captures IN on the rising CLK edge when LOAD is high; otherwise holds its value.
- Synchronous active-high reset returns it to a parameterised value.

Parameters:
- SIZE, 32, data width in bits; legal range 1..64.
- RESET_VALUE, 0 (SIZE bits), value loaded into OUT on reset.

Ports:
- CLK  input  1  rising-edge clock; all state changes on this edge.
- RESET  input  1  synchronous, active-high reset.
- LOAD  input  1  load enable; when high at a rising edge, IN is captured.
- IN  input  SIZE  data to be stored.
- OUT  output  SIZE  registered contents; driven directly by flops, no combinational path from IN.
- LOADED  output  1  high once at least one load has occurred since the last reset.

Behaviour:
- All state updates happen only on the rising edge of CLK. There are no asynchronous paths.
- Priority at each rising edge:
  - RESET=1: OUT <= RESET_VALUE, LOADED <= 0. LOAD and IN are ignored.
  - RESET=0, LOAD=1: OUT <= IN, LOADED <= 1.
  - RESET=0, LOAD=0: OUT and LOADED hold.
- Latency: IN sampled at edge N is visible on OUT immediately after edge N (1-cycle capture). Changes on IN while LOAD=0 never reach OUT.
- Reset values: OUT=RESET_VALUE, LOADED=0.
- Before the first reset, OUT and LOADED are undefined; simulation X is acceptable.
- Reset mid-operation: reset wins over a simultaneous LOAD. Data presented on that edge is lost.
- Back-to-back loads: LOAD held high for several cycles captures IN on every edge. OUT tracks IN with one cycle of delay.
- Width: IN and OUT are exactly SIZE bits. No truncation or extension inside the block.
- LOAD and IN must be stable around the rising edge. Glitches between edges have no effect.

Optional Feature:
- Macro: REGISTER_PARITY_EN.
- When defined:
  - An extra output PARITY_ERR (1 bit) is present.
  - The block stores an even-parity bit, computed over IN at every load and over RESET_VALUE at reset.
  - PARITY_ERR is combinational: high when the XOR of OUT and the stored parity bit is 1.
  - PARITY_ERR is 0 after reset and after every load.
- When not defined: no PARITY_ERR port, no parity flop, and behaviour is otherwise identical.

Decomposition:
- Shared datapath package holds:
  - XLEN = 32 (default for SIZE).
  - The zero constant used as the RESET_VALUE default.
- Sub-module: parity_gen (SIZE-wide XOR reduction). It is instantiated only under REGISTER_PARITY_EN and reused for the stored parity and the check. Otherwise the block is flat.

Test Plan:
- Reset: RESET=1 for one edge with LOAD=1, IN=45. Required: OUT=0 and LOADED=0 (reset beats load).
- Basic load: SIZE=32, RESET=0, LOAD=1, IN=45 across one rising edge. Required: OUT=45 right after that edge, LOADED=1.
- Hold: LOAD=0, IN changed to 450 over the next edges. Required: OUT stays 45 at every edge.
- Back-to-back: LOAD=1 with IN=1,2,3 on consecutive edges. Required: OUT=1,2,3 on the corresponding edges.
- Reset after data: with OUT=45, assert RESET for one edge. Required: OUT returns to RESET_VALUE. Also re-run with RESET_VALUE=32'hDEADBEEF to check the override.
- Parity (REGISTER_PARITY_EN): load IN=32'h7, then force one OUT bit via the bench. Required: PARITY_ERR=0 after the load, and 1 after the forced bit flip.
